// File: rtl/renamed_register_file_pkg.sv
// Shared sizing defaults for the rename-aware register file, decoder and ROB.
package renamed_register_file_pkg;

  localparam int unsigned DEFAULT_XLEN      = 32;
  localparam int unsigned DEFAULT_REG_NUM   = 32;
  localparam int unsigned DEFAULT_ROB_WIDTH = 3;
  localparam int unsigned DEFAULT_REG_W     = $clog2(DEFAULT_REG_NUM);

  // Where a read port takes its operand from.
  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_VALUE,
    SRC_COMMIT,
    SRC_ROB,
    SRC_WAIT
  } read_src_e;

endpackage

// File: rtl/renamed_register_file_reg_read_port.sv
// Per-port operand resolve: register value, commit bypass, ROB forward or pending tag.
module reg_read_port
  import renamed_register_file_pkg::*;
#(
  parameter int unsigned XLEN      = DEFAULT_XLEN,
  parameter int unsigned REG_W     = DEFAULT_REG_W,
  parameter int unsigned ROB_WIDTH = DEFAULT_ROB_WIDTH
) (
  input  logic [REG_W-1:0]     reg_id_i,
  input  logic [XLEN-1:0]      reg_value_i,
  input  logic                 reg_pending_i,
  input  logic [ROB_WIDTH-1:0] reg_dependency_i,
  input  logic                 commit_valid_i,
  input  logic [REG_W-1:0]     commit_reg_id_i,
  input  logic [ROB_WIDTH-1:0] commit_rob_id_i,
  input  logic [XLEN-1:0]      commit_data_i,
  input  logic                 rob_query_ready_i,
  input  logic [XLEN-1:0]      rob_query_data_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 pending_o,
  output logic [ROB_WIDTH-1:0] dependency_o
);

  read_src_e src;

  always_comb begin
    src = SRC_WAIT;
    if (reg_id_i == '0) begin
      src = SRC_ZERO;
    end else if (!reg_pending_i) begin
      src = (commit_valid_i && commit_reg_id_i == reg_id_i) ? SRC_COMMIT : SRC_VALUE;
    end else if (commit_valid_i && commit_rob_id_i == reg_dependency_i) begin
      src = SRC_COMMIT;
    end else if (rob_query_ready_i) begin
      src = SRC_ROB;
    end
  end

  always_comb begin
    data_o       = '0;
    pending_o    = 1'b0;
    dependency_o = reg_dependency_i;
    unique case (src)
      SRC_ZERO:   data_o = '0;
      SRC_VALUE:  data_o = reg_value_i;
      SRC_COMMIT: data_o = commit_data_i;
      SRC_ROB:    data_o = rob_query_data_i;
      default:    pending_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/renamed_register_file.sv
// Architectural register file with rename tags, commit bypass and ROB forwarding.
module renamed_register_file
  import renamed_register_file_pkg::*;
#(
  parameter int unsigned XLEN       = DEFAULT_XLEN,
  parameter int unsigned REG_NUM    = DEFAULT_REG_NUM,
  parameter int unsigned ROB_WIDTH  = DEFAULT_ROB_WIDTH,
  parameter int unsigned READ_PORTS = 2,
  localparam int unsigned REG_W     = $clog2(REG_NUM)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush,
  input  logic                           issue_valid,
  input  logic [REG_W-1:0]               issue_reg_id,
  input  logic [ROB_WIDTH-1:0]           issue_rob_id,
  input  logic                           commit_valid,
  input  logic [REG_W-1:0]               commit_reg_id,
  input  logic [XLEN-1:0]                commit_data,
  input  logic [ROB_WIDTH-1:0]           commit_rob_id,
  input  logic [READ_PORTS*REG_W-1:0]    rd_reg_id,
  output logic [READ_PORTS*XLEN-1:0]     rd_data,
  output logic [READ_PORTS-1:0]          rd_pending,
  output logic [READ_PORTS*ROB_WIDTH-1:0] rd_dependency,
  output logic [READ_PORTS*ROB_WIDTH-1:0] rob_query_id,
  input  logic [READ_PORTS-1:0]          rob_query_ready,
  input  logic [READ_PORTS*XLEN-1:0]     rob_query_data
);

  logic [XLEN-1:0]      value_q      [REG_NUM];
  logic [XLEN-1:0]      value_d      [REG_NUM];
  logic [ROB_WIDTH-1:0] dependency_q [REG_NUM];
  logic [ROB_WIDTH-1:0] dependency_d [REG_NUM];
  logic [REG_NUM-1:0]   pending_q;
  logic [REG_NUM-1:0]   pending_d;

  // Commit first, then flush/issue override: a younger rename beats an older commit clear.
  always_comb begin
    value_d      = value_q;
    dependency_d = dependency_q;
    pending_d    = pending_q;
    if (commit_valid && commit_reg_id != '0) begin
      value_d[commit_reg_id] = commit_data;
      if (pending_q[commit_reg_id] && dependency_q[commit_reg_id] == commit_rob_id) begin
        pending_d[commit_reg_id] = 1'b0;
      end
    end
    if (flush) begin
      pending_d = '0;
    end else if (issue_valid && issue_reg_id != '0) begin
      pending_d[issue_reg_id]    = 1'b1;
      dependency_d[issue_reg_id] = issue_rob_id;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        value_q[i]      <= '0;
        dependency_q[i] <= '0;
      end
      pending_q <= '0;
    end else if (rdy_in) begin
      value_q      <= value_d;
      dependency_q <= dependency_d;
      pending_q    <= pending_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [REG_W-1:0] id;
    assign id = rd_reg_id[p*REG_W +: REG_W];
    assign rob_query_id[p*ROB_WIDTH +: ROB_WIDTH] = dependency_q[id];

    reg_read_port #(
      .XLEN      (XLEN),
      .REG_W     (REG_W),
      .ROB_WIDTH (ROB_WIDTH)
    ) u_port (
      .reg_id_i          (id),
      .reg_value_i       (value_q[id]),
      .reg_pending_i     (pending_q[id]),
      .reg_dependency_i  (dependency_q[id]),
      .commit_valid_i    (commit_valid),
      .commit_reg_id_i   (commit_reg_id),
      .commit_rob_id_i   (commit_rob_id),
      .commit_data_i     (commit_data),
      .rob_query_ready_i (rob_query_ready[p]),
      .rob_query_data_i  (rob_query_data[p*XLEN +: XLEN]),
      .data_o            (rd_data[p*XLEN +: XLEN]),
      .pending_o         (rd_pending[p]),
      .dependency_o      (rd_dependency[p*ROB_WIDTH +: ROB_WIDTH])
    );
  end

endmodule

// File: tb/tb_renamed_register_file.sv
// Directed bench for renamed_register_file with hand-computed expectations.
module tb_renamed_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_reg_id;
  logic [2:0]  issue_rob_id;
  logic        commit_valid;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_data;
  logic [2:0]  commit_rob_id;
  logic [9:0]  rd_reg_id;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic [5:0]  rd_dependency;
  logic [5:0]  rob_query_id;
  logic [1:0]  rob_query_ready;
  logic [63:0] rob_query_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  renamed_register_file #(
    .XLEN       (32),
    .REG_NUM    (32),
    .ROB_WIDTH  (3),
    .READ_PORTS (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_reg_id    (issue_reg_id),
    .issue_rob_id    (issue_rob_id),
    .commit_valid    (commit_valid),
    .commit_reg_id   (commit_reg_id),
    .commit_data     (commit_data),
    .commit_rob_id   (commit_rob_id),
    .rd_reg_id       (rd_reg_id),
    .rd_data         (rd_data),
    .rd_pending      (rd_pending),
    .rd_dependency   (rd_dependency),
    .rob_query_id    (rob_query_id),
    .rob_query_ready (rob_query_ready),
    .rob_query_data  (rob_query_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_reg_id = '0; issue_rob_id = '0;
    commit_valid = 0; commit_reg_id = '0; commit_data = '0; commit_rob_id = '0;
    rob_query_ready = '0; rob_query_data = '0;
  endtask

  task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
    rd_reg_id = {r1, r0};
    #1;
  endtask

  task automatic do_issue(input logic [4:0] r, input logic [2:0] t);
    issue_valid = 1; issue_reg_id = r; issue_rob_id = t;
  endtask

  task automatic do_commit(input logic [4:0] r, input logic [2:0] t, input logic [31:0] d);
    commit_valid = 1; commit_reg_id = r; commit_rob_id = t; commit_data = d;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; rd_reg_id = '0;
    idle();
    tick(); tick();
    rst_in = 0;

    rd(5, 5);
    chk("reset_data0", rd_data[31:0], 32'h0);
    chk("reset_pend0", {31'b0, rd_pending[0]}, 32'h0);
    chk("reset_data1", rd_data[63:32], 32'h0);
    chk("reset_pend1", {31'b0, rd_pending[1]}, 32'h0);

    // rename x5 -> tag 3, then ROB forwarding on port 0 only
    do_issue(5, 3);
    tick(); idle();
    rd(5, 5);
    chk("pend_x5", {31'b0, rd_pending[0]}, 32'h1);
    chk("dep_x5", {29'b0, rd_dependency[2:0]}, 32'h3);
    chk("query_id_x5", {29'b0, rob_query_id[2:0]}, 32'h3);
    rob_query_ready = 2'b01; rob_query_data[31:0] = 32'hAB;
    #1;
    chk("fwd_data", rd_data[31:0], 32'hAB);
    chk("fwd_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("nofwd_pend1", {31'b0, rd_pending[1]}, 32'h1);
    rob_query_ready = '0;

    // younger rename survives older commit
    do_issue(5, 6);
    tick(); idle();
    do_commit(5, 3, 32'h11);
    rd(5, 5);
    chk("oldcommit_samecyc_pend", {31'b0, rd_pending[0]}, 32'h1);
    tick(); idle();
    rd(5, 5);
    chk("after_old_pend", {31'b0, rd_pending[0]}, 32'h1);
    chk("after_old_dep", {29'b0, rd_dependency[2:0]}, 32'h6);
    do_commit(5, 6, 32'h22);
    #1;
    chk("bypass_tag6_data", rd_data[31:0], 32'h22);
    chk("bypass_tag6_pend", {31'b0, rd_pending[0]}, 32'h0);
    tick(); idle();
    rd(5, 5);
    chk("x5_final_data", rd_data[31:0], 32'h22);
    chk("x5_final_pend", {31'b0, rd_pending[0]}, 32'h0);

    // commit bypass with simultaneous issue to the same register
    do_issue(7, 2);
    tick(); idle();
    do_commit(7, 2, 32'h55);
    do_issue(7, 4);
    rd(7, 0);
    chk("x7_bypass_data", rd_data[31:0], 32'h55);
    chk("x7_bypass_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("x0_data", rd_data[63:32], 32'h0);
    tick(); idle();
    rd(7, 7);
    chk("x7_issue_wins_pend", {31'b0, rd_pending[0]}, 32'h1);
    chk("x7_issue_wins_dep", {29'b0, rd_dependency[2:0]}, 32'h4);

    // flush
    do_issue(1, 1); tick(); idle();
    do_issue(2, 2); tick(); idle();
    do_issue(3, 3); tick(); idle();
    rd(1, 2);
    chk("x1_pend_preflush", {31'b0, rd_pending[0]}, 32'h1);
    chk("x2_pend_preflush", {31'b0, rd_pending[1]}, 32'h1);
    flush = 1;
    do_commit(1, 5, 32'h9);
    do_issue(4, 7);
    tick(); idle();
    rd(1, 2);
    chk("flush_x1_data", rd_data[31:0], 32'h9);
    chk("flush_x1_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("flush_x2_pend", {31'b0, rd_pending[1]}, 32'h0);
    chk("flush_x2_data", rd_data[63:32], 32'h0);
    rd(3, 4);
    chk("flush_x3_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("flush_x4_dropped", {31'b0, rd_pending[1]}, 32'h0);
    rd(7, 7);
    chk("flush_x7_pend", {31'b0, rd_pending[0]}, 32'h0);

    // x0 writes ignored
    do_issue(0, 1);
    do_commit(0, 1, 32'hFF);
    rd(0, 0);
    chk("x0_samecyc_data", rd_data[31:0], 32'h0);
    chk("x0_samecyc_pend", {31'b0, rd_pending[0]}, 32'h0);
    tick(); idle();
    rd(0, 0);
    chk("x0_after_data", rd_data[31:0], 32'h0);
    chk("x0_after_pend", {31'b0, rd_pending[0]}, 32'h0);

    // rdy_in low freezes state
    rdy_in = 0;
    do_issue(4, 5);
    do_commit(2, 0, 32'h33);
    tick(); idle();
    rdy_in = 1;
    rd(4, 2);
    chk("frozen_x4_pend", {31'b0, rd_pending[0]}, 32'h0);
    chk("frozen_x2_data", rd_data[63:32], 32'h0);

    // reset mid-operation, with rdy_in low
    do_issue(6, 1);
    do_commit(3, 0, 32'h44);
    tick(); idle();
    rd(3, 6);
    chk("x3_written", rd_data[31:0], 32'h44);
    chk("x6_pend", {31'b0, rd_pending[1]}, 32'h1);
    rst_in = 1; rdy_in = 0;
    tick();
    rst_in = 0; rdy_in = 1;
    rd(3, 6);
    chk("rst_x3_data", rd_data[31:0], 32'h0);
    chk("rst_x6_pend", {31'b0, rd_pending[1]}, 32'h0);
    chk("rst_x6_query", {29'b0, rob_query_id[5:3]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/renamed_register_file.md
# renamed_register_file

Architectural register file with per-register rename status for the out-of-order core, generalised to N read ports and configurable register and ROB sizes. It sits between the decoder (operand reads and destination renaming at issue), the reorder buffer (operand forwarding queries and in-order commit) and the flush logic. It resolves each operand to one of two outcomes: a ready value, or a pending ROB tag. Resolution uses same-cycle commit bypass and ROB forwarding.

## Interface
Parameters:
- XLEN, 32, data width
- REG_NUM, 32, architectural registers; REG_W = $clog2(REG_NUM)
- ROB_WIDTH, 3, ROB index width
- READ_PORTS, 2, independent operand read ports (>=1)

Ports (one clock; reset is synchronous and active-high):
- clk_in  in  1  clock, all state updates on rising edge
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state (reads stay combinational)
- flush  in  1  misprediction flush
- issue_valid  in  1  decoder dispatches an instruction with a destination
- issue_reg_id  in  REG_W  destination register
- issue_rob_id  in  ROB_WIDTH  ROB entry allocated to it
- commit_valid  in  1  ROB retires an instruction with a destination
- commit_reg_id  in  REG_W  retired destination
- commit_data  in  XLEN  retired value
- commit_rob_id  in  ROB_WIDTH  retiring ROB entry
- rd_reg_id  in  READ_PORTS*REG_W  operand register per port
- rd_data  out  READ_PORTS*XLEN  resolved value (valid when not pending)
- rd_pending  out  READ_PORTS  operand still awaits a result
- rd_dependency  out  READ_PORTS*ROB_WIDTH  ROB tag to wait on
- rob_query_id  out  READ_PORTS*ROB_WIDTH  ROB entry queried for forwarding
- rob_query_ready  in  READ_PORTS  queried entry has its result
- rob_query_data  in  READ_PORTS*XLEN  queried entry's result

## Operation
- State: value[REG_NUM], pending[REG_NUM], dependency[REG_NUM].
- Reset (rst_in=1): all values 0, pending 0, dependency 0; takes priority over rdy_in.
- x0: always reads 0, never pending. Issue and commit to x0 are ignored.
- Commit, when rdy_in=1, commit_valid=1 and reg r!=0:
  - value[r] <= commit_data.
  - If pending[r] and dependency[r]==commit_rob_id, clear pending[r]. A later rename must survive an older commit.
- Issue, when rdy_in=1, issue_valid=1, r!=0 and flush=0:
  - pending[r] <= 1 and dependency[r] <= issue_rob_id.
  - Wins over a same-cycle commit clear on the same register.
- Flush: every pending bit is cleared and dependencies keep their stale contents. A same-cycle commit still writes its value; a same-cycle issue is dropped.
- Read port p, register r, purely combinational, from pre-edge state:
  - r==0: data 0, pending 0.
  - not pending[r]: data = value[r], or commit_data if commit_valid and commit_reg_id==r; pending 0.
  - pending[r] and commit_valid and commit_rob_id==dependency[r]: data commit_data, pending 0.
  - pending[r] and rob_query_ready[p]: data rob_query_data[p], pending 0.
  - otherwise: pending 1, rd_dependency = dependency[r], data 0.
- rob_query_id[p] = dependency[rd_reg_id[p]] at all times.
- Reads never see a same-cycle issue. This lets an instruction read its own destination as a source.

## Timing
- Reads: zero latency, combinational.
- Issue and commit: visible to reads in the cycle after the edge.
- Flush: one cycle; the next cycle reads all registers as ready.
- rdy_in=0: no update, including reset of nothing but state freeze (reset still applies).
- Reset mid-operation: the next cycle equals power-on state.

## Structure
- Shared package: XLEN, REG_NUM, ROB_WIDTH defaults and the REG_W derivation, shared with the decoder and ROB.
- One sub-module, reg_read_port: the per-port resolve mux, instantiated READ_PORTS times by generate.

## Test plan
- Reset, then read x5 on both ports -> data 0, pending 0.
- Issue x5 tag 3; next cycle read x5 with rob_query_ready=0 -> pending 1, dependency 3. Then raise rob_query_ready with data 0xAB -> data 0xAB, pending 0.
- Issue x5 tag 3, issue x5 tag 6, then commit x5 tag 3 data 0x11 -> value 0x11, x5 still pending on 6. Commit tag 6 data 0x22 -> ready, reads 0x22.
- Same cycle: commit x7 tag 2 data 0x55 while reading x7 pending on 2 -> read 0x55 not pending. The next cycle's issue of x7 tag 4 with a simultaneous commit of tag 2 leaves pending with dependency 4.
- Issue x1, x2, x3, then flush together with commit x1 data 0x9 -> the next cycle reads all three not pending and x1 = 0x9. The issue in the flush cycle is dropped.
- Issue or commit to x0 with data 0xFF -> x0 reads 0, not pending. With rdy_in=0, an issue of x4 has no effect.
